// File: rtl/tx_frame_pkg.sv
// Shared definitions for the transmit frame packer: defaults, beat payload,
// FSM state encoding and gear code validation.
package tx_frame_pkg;

   localparam logic [15:0] DEF_SYNC_WORD   = 16'hEB90;
   localparam int unsigned DEF_PAYLOAD_LEN = 64;
   localparam int unsigned DEF_TIMEOUT     = 4096;
   localparam int unsigned DEF_FIFO_AW     = 8;
   localparam int unsigned BYTE_W          = 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HDR0,
      ST_HDR1,
      ST_GEAR,
      ST_LEN,
      ST_PAY,
      ST_CSUM
   } frame_state_e;

   // One byte beat towards the serializer.
   typedef struct packed {
      logic [BYTE_W-1:0] data;
      logic              sop;
      logic              eop;
   } frame_beat_t;

   // Gear codes for which incoming bytes are accepted into the frame buffer.
   function automatic logic gear_is_valid(input logic [BYTE_W-1:0] gear);
      logic ok;
      ok = 1'b0;
      case (gear) inside
         8'h42, 8'h43, [8'h49:8'h4F], 8'h51, 8'h52: ok = 1'b1;
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/frame_byte_fifo.sv
// First-word-fall-through byte FIFO: rd_data_c always shows the oldest entry,
// rd_en pops it. count/full/empty are registered.
module frame_byte_fifo
   import tx_frame_pkg::*;
#(
   parameter int unsigned AW = DEF_FIFO_AW
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [BYTE_W-1:0] wr_data,
   input  logic              rd_en,
   output logic [BYTE_W-1:0] rd_data_c,
   output logic [AW:0]       count,
   output logic              full,
   output logic              empty
);

   localparam int unsigned DEPTH = 2**AW;
   localparam int unsigned CW    = AW + 1;

   logic [BYTE_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic              do_wr_c;
   logic              do_rd_c;
   logic [CW-1:0]     count_nxt_c;

   // Qualified pointer moves and next occupancy.
   always_comb begin
      do_wr_c     = wr_en & ~full;
      do_rd_c     = rd_en & ~empty;
      count_nxt_c = count;
      case ({do_wr_c, do_rd_c})
         2'b10:   count_nxt_c = count + CW'(1);
         2'b01:   count_nxt_c = count - CW'(1);
         default: count_nxt_c = count;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         if (do_wr_c) wr_ptr <= wr_ptr + AW'(1);
         if (do_rd_c) rd_ptr <= rd_ptr + AW'(1);
         count <= count_nxt_c;
         full  <= (count_nxt_c == CW'(DEPTH));
         empty <= (count_nxt_c == '0);
      end
   end

   // Storage carries no reset; pointers alone define the contents.
   always_ff @(posedge clk) begin
      if (do_wr_c) mem[wr_ptr] <= wr_data;
   end

   assign rd_data_c = mem[rd_ptr];

endmodule

// File: rtl/tx_frame_packer.sv
// Buffers the gear-tagged byte stream and emits frames
// (sync, gear, length, payload, checksum) over a valid/ready byte interface.
module tx_frame_packer
   import tx_frame_pkg::*;
#(
   parameter int unsigned PAYLOAD_LEN = DEF_PAYLOAD_LEN,
   parameter int unsigned FIFO_AW     = DEF_FIFO_AW,
   parameter int unsigned TIMEOUT     = DEF_TIMEOUT,
   parameter logic [15:0] SYNC_WORD   = DEF_SYNC_WORD
)(
   input  logic        clk100m,
   input  logic        rst_n,
   input  logic [7:0]  i_down_gear,
   input  logic [7:0]  i_data,
   input  logic        i_data_valid,
   output logic [7:0]  o_frame_data,
   output logic        o_frame_valid,
   input  logic        i_frame_ready,
   output logic        o_frame_sop,
   output logic        o_frame_eop,
   output logic        o_overflow,
   output logic [15:0] o_drop_cnt
);

   localparam int unsigned CW = FIFO_AW + 1;
   localparam int unsigned TW = $clog2(TIMEOUT);

   frame_state_e      state;
   frame_beat_t       beat_q;
   logic              valid_q;
   logic [BYTE_W-1:0] gear_q;
   logic [BYTE_W-1:0] frame_gear;
   logic [BYTE_W-1:0] len_q;
   logic [BYTE_W-1:0] remain;
   logic [BYTE_W-1:0] csum;
   logic [TW-1:0]     idle_timer;
   logic              overflow_q;
   logic [15:0]       drop_cnt_q;

   logic [BYTE_W-1:0] fifo_data_c;
   logic [CW-1:0]     fifo_count;
   logic              fifo_full;
   logic              fifo_empty;

   logic              gear_ok_c;
   logic              wr_en_c;
   logic              drop_c;
   logic              fire_c;
   logic              start_c;
   logic              pop_c;
   logic [BYTE_W-1:0] start_len_c;

   frame_byte_fifo #(
      .AW (FIFO_AW)
   ) u_fifo (
      .clk       (clk100m),
      .rst_n     (rst_n),
      .wr_en     (wr_en_c),
      .wr_data   (i_data),
      .rd_en     (pop_c),
      .rd_data_c (fifo_data_c),
      .count     (fifo_count),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // Write/drop qualification, frame start decision and payload pop.
   always_comb begin
      gear_ok_c   = gear_is_valid(i_down_gear);
      wr_en_c     = i_data_valid & gear_ok_c & ~fifo_full;
      drop_c      = i_data_valid & gear_ok_c & fifo_full;
      fire_c      = valid_q & i_frame_ready;
      start_c     = 1'b0;
      if ((state == ST_IDLE) && (fifo_count != '0)) begin
         start_c = (fifo_count >= CW'(PAYLOAD_LEN)) ||
                   (idle_timer == TW'(TIMEOUT - 1)) ||
                   (i_down_gear != gear_q);
      end
      start_len_c = (fifo_count >= CW'(PAYLOAD_LEN)) ? BYTE_W'(PAYLOAD_LEN)
                                                     : BYTE_W'(fifo_count);
      pop_c       = fire_c & ~fifo_empty &
                    ((state == ST_LEN) || ((state == ST_PAY) && (remain != '0)));
   end

   // Overflow pulse and saturating drop counter.
   always_ff @(posedge clk100m or negedge rst_n) begin
      if (!rst_n) begin
         overflow_q <= 1'b0;
         drop_cnt_q <= '0;
      end else begin
         overflow_q <= drop_c;
         if (drop_c && (drop_cnt_q != 16'hFFFF)) drop_cnt_q <= drop_cnt_q + 16'd1;
      end
   end

   // Gear tracking and idle timer run only while idle, so a gear change made
   // during a frame is still seen as a change once the frame completes.
   always_ff @(posedge clk100m or negedge rst_n) begin
      if (!rst_n) begin
         gear_q     <= '0;
         idle_timer <= '0;
      end else if (state == ST_IDLE) begin
         gear_q <= i_down_gear;
         if (wr_en_c || start_c || (fifo_count == '0)) idle_timer <= '0;
         else                                          idle_timer <= idle_timer + TW'(1);
      end else begin
         idle_timer <= '0;
      end
   end

   // Frame sequencer; the presented beat is registered and changes only on a handshake.
   always_ff @(posedge clk100m or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         beat_q     <= '0;
         valid_q    <= 1'b0;
         frame_gear <= '0;
         len_q      <= '0;
         remain     <= '0;
         csum       <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start_c) begin
                  state      <= ST_HDR0;
                  valid_q    <= 1'b1;
                  beat_q     <= '{data: SYNC_WORD[15:8], sop: 1'b1, eop: 1'b0};
                  frame_gear <= gear_q;
                  len_q      <= start_len_c;
               end
            end
            ST_HDR0: begin
               if (fire_c) begin
                  state  <= ST_HDR1;
                  beat_q <= '{data: SYNC_WORD[7:0], sop: 1'b0, eop: 1'b0};
               end
            end
            ST_HDR1: begin
               if (fire_c) begin
                  state       <= ST_GEAR;
                  beat_q.data <= frame_gear;
                  csum        <= frame_gear;
               end
            end
            ST_GEAR: begin
               if (fire_c) begin
                  state       <= ST_LEN;
                  beat_q.data <= len_q;
                  csum        <= csum + len_q;
               end
            end
            ST_LEN: begin
               if (fire_c) begin
                  state       <= ST_PAY;
                  beat_q.data <= fifo_data_c;
                  csum        <= csum + fifo_data_c;
                  remain      <= len_q - 8'd1;
               end
            end
            ST_PAY: begin
               if (fire_c) begin
                  if (remain == '0) begin
                     state  <= ST_CSUM;
                     beat_q <= '{data: csum, sop: 1'b0, eop: 1'b1};
                  end else begin
                     beat_q.data <= fifo_data_c;
                     csum        <= csum + fifo_data_c;
                     remain      <= remain - 8'd1;
                  end
               end
            end
            ST_CSUM: begin
               if (fire_c) begin
                  state   <= ST_IDLE;
                  valid_q <= 1'b0;
                  beat_q  <= '0;
               end
            end
            default: begin
               state   <= ST_IDLE;
               valid_q <= 1'b0;
               beat_q  <= '0;
            end
         endcase
      end
   end

   assign o_frame_data  = beat_q.data;
   assign o_frame_sop   = beat_q.sop;
   assign o_frame_eop   = beat_q.eop;
   assign o_frame_valid = valid_q;
   assign o_overflow    = overflow_q;
   assign o_drop_cnt    = drop_cnt_q;

endmodule
